// File: rtl/t03_text_pkg.sv
// -----------------------------------------------------------------------------
// t03_text_pkg
// Shared types and constants for the scanline text overlay.
//   ovl_state_e   : per-line renderer state (idle / fetching / armed / shifting)
//   DEF_X_OFFSET  : default horizontal offset added to x to form the box edge
//   DEF_Y_OFFSET  : default vertical offset added to y to form the box edge
//   COLOR_BLACK   : colour driven outside the box when not transparent
//   in_span()     : overflow-safe "lo <= pos < lo+len" compare on 12-bit values
// -----------------------------------------------------------------------------
package t03_text_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ARMED,
    ST_SHIFT
  } ovl_state_e;

  localparam int DEF_X_OFFSET = 37;
  localparam int DEF_Y_OFFSET = 29;

  localparam logic [7:0] COLOR_BLACK = 8'h00;

  // Compare in 13 bits so a box edge near the top of the 12-bit range cannot
  // wrap its far edge back to a small value.
  function automatic logic in_span(input logic [11:0] pos,
                                   input logic [11:0] lo,
                                   input logic [11:0] len);
    return ({1'b0, pos} >= {1'b0, lo}) &&
           ({1'b0, pos} <  ({1'b0, lo} + {1'b0, len}));
  endfunction

endpackage

// File: rtl/t03_text_overlay_if.sv
// -----------------------------------------------------------------------------
// t03_text_overlay_if
// Bitmap row fetch port between the overlay (master) and the glyph row store
// (slave).
//   row_req  : master -> slave, request held until row_ack
//   row_addr : master -> slave, bitmap row index, stable while row_req
//   row_ack  : slave -> master, row_data is valid in this cycle
//   row_data : slave -> master, one bitmap row, MSB = leftmost pixel
// -----------------------------------------------------------------------------
interface t03_text_overlay_if #(
  parameter int ROW_W = 108,
  parameter int RA_W  = 3
);

  logic             row_req;
  logic [RA_W-1:0]  row_addr;
  logic             row_ack;
  logic [ROW_W-1:0] row_data;

  modport master (
    output row_req,
    output row_addr,
    input  row_ack,
    input  row_data
  );

  modport slave (
    input  row_req,
    input  row_addr,
    output row_ack,
    output row_data
  );

endinterface

// File: rtl/t03_text_row_shifter.sv
// -----------------------------------------------------------------------------
// t03_text_row_shifter
// Holds one fetched bitmap row and presents it MSB-first, each bit lasting
// 2**SCALE_LOG2 clocks while run is high.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture data and restart the bit/scale counters
//   data     : bitmap row, MSB = first pixel
//   run      : advance the scale counter this clock
//   bit_out  : current pixel bit (shifter MSB)
//   done     : high on the final clock of the last bit
// -----------------------------------------------------------------------------
module t03_text_row_shifter #(
  parameter int ROW_W      = 108,
  parameter int SCALE_LOG2 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ROW_W-1:0] data,
  input  logic             run,
  output logic             bit_out,
  output logic             done
);

  localparam int SC_W = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int BC_W = $clog2(ROW_W);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'((1 << SCALE_LOG2) - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(ROW_W - 1);

  logic [ROW_W-1:0] sreg;
  logic [SC_W-1:0]  scale_cnt;
  logic [BC_W-1:0]  bit_cnt;
  logic             step;

  assign step    = run && (scale_cnt == SC_MAX);
  assign bit_out = sreg[ROW_W-1];
  assign done    = step && (bit_cnt == BC_LAST);

  // NOTE: the row register is pure datapath and is always loaded before it is
  // read, so it carries no reset; only the control counters are reset.
  always_ff @(posedge clk) begin
    if (load) begin
      sreg <= data;
    end else if (step) begin
      sreg <= {sreg[ROW_W-2:0], 1'b0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scale_cnt <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      scale_cnt <= '0;
      bit_cnt   <= '0;
    end else if (step) begin
      scale_cnt <= '0;
      bit_cnt   <= bit_cnt + 1'b1;
    end else if (run) begin
      scale_cnt <= scale_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/t03_text_overlay.sv
// -----------------------------------------------------------------------------
// t03_text_overlay
// Scanline text renderer. On each line that crosses the text box it fetches one
// bitmap row over the fetch port before the box starts, then shifts it out
// MSB-first with integer horizontal scaling and fg/bg/transparent colouring.
//   clk, rst            : pixel clock, asynchronous active-high reset
//   hcnt, vcnt          : VGA counters (hcnt==0 line start, vcnt==0 frame start)
//   x, y                : box position before the fixed offsets
//   enable              : overlay enable, sampled at line start
//   transparent         : background pixels pass pixel_in
//   fg_color, bg_color  : set-bit colour / clear-bit colour
//   pixel_in            : underlying pixel aligned with hcnt
//   fetch (master)      : row_req / row_addr / row_ack / row_data
//   color, active, miss : registered colour, in-box flag, fetch deadline miss
// -----------------------------------------------------------------------------
module t03_text_overlay
  import t03_text_pkg::*;
#(
  parameter int CHAR_W       = 9,
  parameter int NUM_CHARS    = 12,
  parameter int CHAR_H       = 8,
  parameter int SCALE_X_LOG2 = 0,
  parameter int SCALE_Y_LOG2 = 2,
  parameter int X_OFFSET     = DEF_X_OFFSET,
  parameter int Y_OFFSET     = DEF_Y_OFFSET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcnt,
  input  logic [10:0] vcnt,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        enable,
  input  logic        transparent,
  input  logic [7:0]  fg_color,
  input  logic [7:0]  bg_color,
  input  logic [7:0]  pixel_in,
  t03_text_overlay_if.master fetch,
  output logic [7:0]  color,
  output logic        active,
  output logic        miss
);

  localparam int ROW_W = CHAR_W * NUM_CHARS;
  localparam int RA_W  = $clog2(CHAR_H);
  localparam logic [11:0] BOX_H = 12'(CHAR_H << SCALE_Y_LOG2);

  ovl_state_e       state;
  logic [11:0]      x0_q;
  logic [11:0]      y0_q;
  logic             row_req_q;
  logic [RA_W-1:0]  row_addr_q;

  logic [11:0]      hcnt_w;
  logic [11:0]      vcnt_w;
  logic [11:0]      hcnt_p1;
  logic [11:0]      y0_eff;
  logic [11:0]      y_rel;
  logic [RA_W-1:0]  row_sel;
  logic             line_start;
  logic             line_in_box;
  logic             no_window;
  logic             deadline;
  logic             arm_now;
  logic             ack_ok;
  logic             sh_load;
  logic             sh_bit;
  logic             sh_done;
  logic [7:0]       next_color;

  assign hcnt_w     = {1'b0, hcnt};
  assign vcnt_w     = {1'b0, vcnt};
  assign hcnt_p1    = hcnt_w + 12'd1;
  assign line_start = (hcnt == '0);

  // On the first line of a frame the new Y0 is being latched this very cycle;
  // use it directly so that line is judged against the fresh box position.
  assign y0_eff      = (line_start && vcnt == '0) ? ({1'b0, y} + 12'(Y_OFFSET)) : y0_q;
  assign line_in_box = in_span(vcnt_w, y0_eff, BOX_H);
  assign y_rel       = vcnt_w - y0_eff;
  assign row_sel     = RA_W'(y_rel >> SCALE_Y_LOG2);

  // The FSM is one cycle ahead of the pixel it colours: it must already be in
  // SHIFT while hcnt==X0, so arming and the deadline both look at hcnt+1.
  // With X0<=1 there is no fetch window at all; such a line always misses.
  assign no_window = (x0_q <= 12'd1);
  assign deadline  = (hcnt_p1 >= x0_q);
  assign arm_now   = (hcnt_p1 == x0_q);
  assign ack_ok    = fetch.row_ack && !no_window;
  assign sh_load   = (state == ST_FETCH) && ack_ok && !line_start;

  assign fetch.row_req  = row_req_q;
  assign fetch.row_addr = row_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      row_req_q  <= 1'b0;
      row_addr_q <= '0;
      miss       <= 1'b0;
      x0_q       <= 12'(X_OFFSET);
      y0_q       <= 12'(Y_OFFSET);
    end else begin
      miss <= 1'b0;
      if (line_start) begin
        x0_q <= {1'b0, x} + 12'(X_OFFSET);
        if (vcnt == '0) begin
          y0_q <= y0_eff;
        end
        if (enable && line_in_box) begin
          state      <= ST_FETCH;
          row_req_q  <= 1'b1;
          row_addr_q <= row_sel;
        end else begin
          state     <= ST_IDLE;
          row_req_q <= 1'b0;
        end
      end else begin
        unique case (state)
          ST_FETCH: begin
            if (ack_ok) begin
              row_req_q <= 1'b0;
              state     <= arm_now ? ST_SHIFT : ST_ARMED;
            end else if (deadline) begin
              row_req_q <= 1'b0;
              miss      <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          ST_ARMED: begin
            if (arm_now) begin
              state <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (sh_done) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  t03_text_row_shifter #(
    .ROW_W      (ROW_W),
    .SCALE_LOG2 (SCALE_X_LOG2)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .data    (fetch.row_data),
    .run     (state == ST_SHIFT),
    .bit_out (sh_bit),
    .done    (sh_done)
  );

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_color = transparent ? pixel_in : COLOR_BLACK;
    if (state == ST_SHIFT) begin
      if (sh_bit) begin
        next_color = fg_color;
      end else if (!transparent) begin
        next_color = bg_color;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color  <= COLOR_BLACK;
      active <= 1'b0;
    end else begin
      color  <= next_color;
      active <= (state == ST_SHIFT);
    end
  end

endmodule
